// File: rtl/tag_mac_backoff_pkg.sv
// Shared types and helpers for the backscatter tag random-access MAC.
package tag_mac_pkg;

    // Encoded MAC state, also exported on mac_state for debug.
    typedef enum logic [2:0] {
        MAC_IDLE     = 3'd0,
        MAC_BACKOFF  = 3'd1,
        MAC_TX       = 3'd2,
        MAC_WAIT_ACK = 3'd3
    } mac_state_t;

    // Galois right-shift feedback mask for the 16-bit access LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Bit width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/tag_mac_backoff_if.sv
// Handshake and data bundle between the excitation/reader side and the MAC.
interface tag_mac_backoff_if #(
    parameter int DATA_WIDTH = 20,
    parameter int CH_WIDTH   = 2
);
    logic                  trigger_signal;
    logic                  mac_control_signal;
    logic                  ack;
    logic                  collision;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  data_req;
    logic [DATA_WIDTH-1:0] output_signal;
    logic                  tx_active;
    logic [CH_WIDTH-1:0]   tx_channel;
    logic                  retry_exhausted;
    logic [2:0]            mac_state;

    // Environment side: drives excitation, reader feedback and payload.
    modport master (
        output trigger_signal, mac_control_signal, ack, collision, tx_data,
        input  data_req, output_signal, tx_active, tx_channel, retry_exhausted, mac_state
    );

    // MAC side.
    modport slave (
        input  trigger_signal, mac_control_signal, ack, collision, tx_data,
        output data_req, output_signal, tx_active, tx_channel, retry_exhausted, mac_state
    );
endinterface

// File: rtl/tag_mac_backoff_lfsr.sv
// Free-running 16-bit Galois LFSR used for backoff draws and channel picks.
module tag_lfsr16
    import tag_mac_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);

    // An all-zero state would lock the register, so a zero seed becomes 1.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Shift right each enabled cycle, folding the taps in when bit 0 falls out.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= SEED_NZ;
        end else if (enable) begin
            if (state[0]) begin
                state <= (state >> 1) ^ LFSR_TAPS;
            end else begin
                state <= state >> 1;
            end
        end
    end

endmodule

// File: rtl/tag_mac_backoff.sv
// Random-access MAC for the OFDM backscatter tag: exponential backoff,
// burst transmission on a random channel, ack/collision driven retry.
//
// state        | meaning
// -------------+---------------------------------------------------------
// MAC_IDLE     | waiting for a trigger rising edge with MAC enabled
// MAC_BACKOFF  | counting down the drawn number of backoff slots
// MAC_TX       | requesting and holding BURST_LEN payload words
// MAC_WAIT_ACK | waiting for reader ack/collision or timeout
module tag_mac_backoff
    import tag_mac_pkg::*;
#(
    parameter int          DATA_WIDTH    = 20,
    parameter int          NUM_CH        = 4,
    parameter int          SLOT_CYCLES   = 64,
    parameter int          SYMBOL_CYCLES = 16,
    parameter int          BURST_LEN     = 8,
    parameter int          CW_MIN_LOG2   = 2,
    parameter int          CW_MAX_LOG2   = 6,
    parameter int          MAX_RETRY     = 3,
    parameter int          ACK_TIMEOUT   = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    tag_mac_backoff_if.slave  bus
);

    localparam int CH_W    = clog2(NUM_CH);
    localparam int SLOT_W  = cnt_width(SLOT_CYCLES);
    localparam int SLOTS_W = CW_MAX_LOG2;
    localparam int SYM_W   = cnt_width(SYMBOL_CYCLES);
    localparam int WORD_W  = cnt_width(BURST_LEN + 1);
    localparam int TO_W    = cnt_width(ACK_TIMEOUT);
    localparam int RETRY_W = cnt_width(MAX_RETRY + 1);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SYM_W-1:0]   SYM_LAST   = SYM_W'(SYMBOL_CYCLES - 1);
    localparam logic [SYM_W-1:0]   SYM_ONE    = SYM_W'(1);
    localparam logic [WORD_W-1:0]  WORDS      = WORD_W'(BURST_LEN);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [3:0]         CW_MIN     = 4'(CW_MIN_LOG2);
    localparam logic [3:0]         CW_MAX     = 4'(CW_MAX_LOG2);
    localparam bit                 SINGLE_SYM = (SYMBOL_CYCLES == 1);

    mac_state_t             state;
    logic                   trig_d;
    logic [15:0]            lfsr;
    logic [SLOT_W-1:0]      slot_tmr;
    logic [SLOTS_W-1:0]     slots;
    logic [SYM_W-1:0]       sym_tmr;
    logic [WORD_W-1:0]      word_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [RETRY_W-1:0]     retry_cnt;
    logic [3:0]             cw_log2;

    logic                   data_req_q;
    logic [DATA_WIDTH-1:0]  out_q;
    logic                   tx_active_q;
    logic [CH_W-1:0]        tx_channel_q;
    logic                   retry_exhausted_q;

    logic                   trig_edge;
    logic [3:0]             cw_next;
    logic [15:0]            draw_cur;
    logic [15:0]            draw_next;
    logic [RETRY_W-1:0]     retry_inc;
    logic                   attempt_failed;

    tag_lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .state  (lfsr)
    );

    // Edge detect, backoff draws for the current and the widened window, failure decode.
    always_comb begin
        trig_edge      = bus.trigger_signal & ~trig_d;
        cw_next        = (cw_log2 >= CW_MAX) ? CW_MAX : cw_log2 + 4'd1;
        draw_cur       = lfsr & ((16'd1 << cw_log2) - 16'd1);
        draw_next      = lfsr & ((16'd1 << cw_next) - 16'd1);
        retry_inc      = retry_cnt + 1'b1;
        attempt_failed = bus.collision || (to_cnt == TO_LAST);
    end

    // Access state machine, its timers and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= MAC_IDLE;
            trig_d            <= 1'b1;
            slot_tmr          <= '0;
            slots             <= '0;
            sym_tmr           <= '0;
            word_cnt          <= '0;
            to_cnt            <= '0;
            retry_cnt         <= '0;
            cw_log2           <= CW_MIN;
            data_req_q        <= 1'b0;
            out_q             <= '0;
            tx_active_q       <= 1'b0;
            tx_channel_q      <= '0;
            retry_exhausted_q <= 1'b0;
        end else begin
            trig_d            <= bus.trigger_signal;
            data_req_q        <= 1'b0;
            retry_exhausted_q <= 1'b0;
            case (state)
                MAC_IDLE: begin
                    if (trig_edge && bus.mac_control_signal) begin
                        state    <= MAC_BACKOFF;
                        slots    <= draw_cur[SLOTS_W-1:0];
                        slot_tmr <= SLOT_LAST;
                    end
                end
                MAC_BACKOFF: begin
                    if (!bus.mac_control_signal) begin
                        state <= MAC_IDLE;
                    end else if (slot_tmr == '0) begin
                        if (slots == '0) begin
                            state        <= MAC_TX;
                            tx_channel_q <= lfsr[CH_W-1:0];
                            sym_tmr      <= '0;
                            word_cnt     <= '0;
                            data_req_q   <= 1'b1;
                        end else begin
                            slots    <= slots - 1'b1;
                            slot_tmr <= SLOT_LAST;
                        end
                    end else begin
                        slot_tmr <= slot_tmr - 1'b1;
                    end
                end
                MAC_TX: begin
                    // data_req was high this cycle, so tx_data is the next word.
                    if (data_req_q) begin
                        out_q       <= bus.tx_data;
                        tx_active_q <= 1'b1;
                        sym_tmr     <= SYM_LAST;
                        word_cnt    <= word_cnt + 1'b1;
                        if (SINGLE_SYM && ((word_cnt + 1'b1) < WORDS)) begin
                            data_req_q <= 1'b1;
                        end
                    end else if (sym_tmr == '0) begin
                        out_q       <= '0;
                        tx_active_q <= 1'b0;
                        to_cnt      <= '0;
                        state       <= MAC_WAIT_ACK;
                    end else begin
                        sym_tmr <= sym_tmr - 1'b1;
                        // Request the next word so it lands right as this symbol ends.
                        if ((sym_tmr == SYM_ONE) && (word_cnt < WORDS)) begin
                            data_req_q <= 1'b1;
                        end
                    end
                end
                MAC_WAIT_ACK: begin
                    if (bus.ack) begin
                        state     <= MAC_IDLE;
                        cw_log2   <= CW_MIN;
                        retry_cnt <= '0;
                    end else if (attempt_failed) begin
                        if (retry_inc == RETRY_MAX) begin
                            retry_exhausted_q <= 1'b1;
                            state             <= MAC_IDLE;
                            cw_log2           <= CW_MIN;
                            retry_cnt         <= '0;
                        end else begin
                            retry_cnt <= retry_inc;
                            cw_log2   <= cw_next;
                            slots     <= draw_next[SLOTS_W-1:0];
                            slot_tmr  <= SLOT_LAST;
                            state     <= MAC_BACKOFF;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= MAC_IDLE;
                end
            endcase
        end
    end

    assign bus.data_req        = data_req_q;
    assign bus.output_signal   = out_q;
    assign bus.tx_active       = tx_active_q;
    assign bus.tx_channel      = tx_channel_q;
    assign bus.retry_exhausted = retry_exhausted_q;
    assign bus.mac_state       = state;

endmodule

// File: tb/tb_tag_mac_backoff.sv
// Scoreboard bench for tag_mac_backoff: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_tag_mac_backoff;

    localparam int          DW    = 20;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          SLOT  = 64;
    localparam int          SYM   = 16;
    localparam int          BURST = 8;

    localparam int EV_STATE = 0;
    localparam int EV_DREQ  = 1;
    localparam int EV_WORD  = 2;
    localparam int EV_REX   = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic        clock;
    logic        reset;
    int          cyc;
    int          checks;
    int          failures;
    logic [15:0] m_lfsr;
    ev_t         exp_q[$];

    tag_mac_backoff_if #(.DATA_WIDTH(DW), .CH_WIDTH(2)) bus ();

    tag_mac_backoff #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (4),
        .SLOT_CYCLES   (SLOT),
        .SYMBOL_CYCLES (SYM),
        .BURST_LEN     (BURST),
        .CW_MIN_LOG2   (2),
        .CW_MAX_LOG2   (6),
        .MAX_RETRY     (3),
        .ACK_TIMEOUT   (256),
        .LFSR_SEED     (SEED)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsr_step(r);
        return r;
    endfunction

    function automatic logic [DW-1:0] fdat(input int c);
        return DW'((c * 37) ^ 'h5A5A5);
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_STATE: return "state";
            EV_DREQ:  return "data_req";
            EV_WORD:  return "word";
            default:  return "retry_exhausted";
        endcase
    endfunction

    // Cycle counter and reference LFSR, both stepping on the active edge.
    always @(posedge clock) begin
        cyc    <= cyc + 1;
        m_lfsr <= reset ? SEED : lfsr_step(m_lfsr);
    end

    task automatic chk(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, expv);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Expected events of one access entering BACKOFF at cycle s. me is the
    // LFSR value the entry edge uses. Returns TX start and WAIT_ACK entry cycles.
    task automatic access_from(input int s, input logic [15:0] me, input int cw,
                               input int nwords, output int t, output int w);
        int          d;
        logic [15:0] mt;
        d  = int'(me & 16'((1 << cw) - 1));
        t  = s + (d + 1) * SLOT;
        mt = lfsr_adv(me, t - s);
        push_ev(EV_STATE, s, 1);
        push_ev(EV_STATE, t, (int'(mt[1:0]) << 8) | 2);
        for (int k = 0; k < nwords; k++) begin
            push_ev(EV_DREQ, t + SYM * k, 0);
            push_ev(EV_WORD, t + SYM * k + 1, (1 << DW) | int'(fdat(t + SYM * k)));
        end
        w = t + SYM * BURST + 1;
        if (nwords == BURST) push_ev(EV_STATE, w, ((SYM * BURST) << 8) | 3);
    endtask

    // Monitor: turns DUT activity into events and checks them against the queue.
    int   mon_prev_state = 0;
    bit   mon_prev_dreq  = 1'b0;
    int   mon_act_cnt    = 0;

    task automatic mon_cmp(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s at cyc %0d: got val %0h, expected no event", kname(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                failures++;
                $display("FAIL %s: got %s val %0h at cyc %0d, expected %s val %0h at cyc %0d",
                         kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
            end
        end
    endtask

    always @(negedge clock) begin
        int st;
        st = int'(bus.mac_state);
        if (st != mon_prev_state) begin
            if (st == 2) begin
                mon_cmp(EV_STATE, (int'(bus.tx_channel) << 8) | 2);
                mon_act_cnt = 0;
            end else if (st == 3) begin
                mon_cmp(EV_STATE, (mon_act_cnt << 8) | 3);
            end else begin
                mon_cmp(EV_STATE, st);
            end
            mon_prev_state = st;
        end
        if (bus.data_req) mon_cmp(EV_DREQ, 0);
        if (mon_prev_dreq) mon_cmp(EV_WORD, (int'(bus.tx_active) << DW) | int'(bus.output_signal));
        if (bus.retry_exhausted) mon_cmp(EV_REX, 0);
        if (!bus.tx_active) chk("idle_output_zero", int'(bus.output_signal), 0);
        if (bus.tx_active) mon_act_cnt++;
        mon_prev_dreq = bus.data_req;
    end

    // Payload source: a distinct word every cycle.
    initial begin
        bus.tx_data = '0;
        forever begin
            @(negedge clock);
            bus.tx_data = fdat(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cyc %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        int          t;
        int          w;
        logic [15:0] me;

        cyc      = 0;
        checks   = 0;
        failures = 0;
        m_lfsr   = SEED;
        reset    = 1'b1;
        bus.trigger_signal     = 1'b1;
        bus.mac_control_signal = 1'b1;
        bus.ack       = 1'b0;
        bus.collision = 1'b0;

        // Trigger high through reset release is not an edge.
        repeat (3) @(negedge clock);
        chk("reset_state", int'(bus.mac_state), 0);
        chk("reset_tx_active", int'(bus.tx_active), 0);
        chk("reset_data_req", int'(bus.data_req), 0);
        chk("reset_channel", int'(bus.tx_channel), 0);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("held_trigger_idle", int'(bus.mac_state), 0);

        // Rising edge with MAC disabled is ignored.
        bus.trigger_signal     = 1'b0;
        bus.mac_control_signal = 1'b0;
        repeat (2) @(negedge clock);
        bus.trigger_signal = 1'b1;
        repeat (2) @(negedge clock);
        bus.trigger_signal = 1'b0;
        repeat (10) @(negedge clock);
        chk("disabled_edge_idle", int'(bus.mac_state), 0);
        chk("disabled_edge_output", int'(bus.output_signal), 0);

        // Full access, mac_control toggled mid-burst, ack 10 cycles into WAIT_ACK.
        bus.mac_control_signal = 1'b1;
        @(negedge clock);
        bus.trigger_signal = 1'b1;
        s  = cyc + 1;
        me = m_lfsr;
        access_from(s, me, 2, BURST, t, w);
        @(negedge clock);
        bus.trigger_signal = 1'b0;
        wait_cyc(t + 20);
        bus.mac_control_signal = 1'b0;
        wait_cyc(t + 60);
        bus.mac_control_signal = 1'b1;
        wait_cyc(w + 9);
        bus.ack = 1'b1;
        push_ev(EV_STATE, w + 10, 0);
        @(negedge clock);
        bus.ack = 1'b0;

        // Three collisions: window widens 2 -> 3 -> 4, then give up.
        repeat (5) @(negedge clock);
        bus.trigger_signal = 1'b1;
        s  = cyc + 1;
        me = m_lfsr;
        access_from(s, me, 2, BURST, t, w);
        @(negedge clock);
        bus.trigger_signal = 1'b0;
        for (int a = 0; a < 2; a++) begin
            wait_cyc(w + 4);
            bus.collision = 1'b1;
            me = m_lfsr;
            access_from(w + 5, me, 3 + a, BURST, t, w);
            @(negedge clock);
            bus.collision = 1'b0;
        end
        wait_cyc(w + 4);
        bus.collision = 1'b1;
        push_ev(EV_STATE, w + 5, 0);
        push_ev(EV_REX, w + 5, 0);
        @(negedge clock);
        bus.collision = 1'b0;

        // Silent reader: failure exactly ACK_TIMEOUT cycles after WAIT_ACK entry.
        repeat (5) @(negedge clock);
        bus.trigger_signal = 1'b1;
        s  = cyc + 1;
        me = m_lfsr;
        access_from(s, me, 2, BURST, t, w);
        @(negedge clock);
        bus.trigger_signal = 1'b0;
        wait_cyc(w + 255);
        me = m_lfsr;
        access_from(w + 256, me, 3, BURST, t, w);
        // ack and collision together count as ack.
        wait_cyc(w + 3);
        bus.ack       = 1'b1;
        bus.collision = 1'b1;
        push_ev(EV_STATE, w + 4, 0);
        @(negedge clock);
        bus.ack       = 1'b0;
        bus.collision = 1'b0;

        // MAC disabled mid-backoff: back to IDLE next cycle, no data_req.
        repeat (5) @(negedge clock);
        bus.trigger_signal = 1'b1;
        s = cyc + 1;
        push_ev(EV_STATE, s, 1);
        @(negedge clock);
        bus.trigger_signal = 1'b0;
        wait_cyc(s + 5);
        bus.mac_control_signal = 1'b0;
        push_ev(EV_STATE, s + 6, 0);
        repeat (300) @(negedge clock);
        chk("mac_drop_idle", int'(bus.mac_state), 0);
        bus.mac_control_signal = 1'b1;

        // Reset in the middle of a burst clears everything at the next edge.
        repeat (5) @(negedge clock);
        bus.trigger_signal = 1'b1;
        s  = cyc + 1;
        me = m_lfsr;
        access_from(s, me, 2, 3, t, w);
        @(negedge clock);
        bus.trigger_signal = 1'b0;
        wait_cyc(t + 40);
        chk("mid_tx_active", int'(bus.tx_active), 1);
        reset = 1'b1;
        push_ev(EV_STATE, t + 41, 0);
        @(negedge clock);
        chk("rst_mid_tx_output", int'(bus.output_signal), 0);
        chk("rst_mid_tx_active", int'(bus.tx_active), 0);
        chk("rst_mid_tx_data_req", int'(bus.data_req), 0);
        chk("rst_mid_tx_channel", int'(bus.tx_channel), 0);
        chk("rst_mid_tx_rex", int'(bus.retry_exhausted), 0);
        chk("rst_mid_tx_state", int'(bus.mac_state), 0);
        reset = 1'b0;

        repeat (20) @(negedge clock);
        chk("events_outstanding", exp_q.size(), 0);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            $display("FAIL missing_%s: got nothing, expected val %0h at cyc %0d", kname(e.kind), e.val, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tag_mac_backoff.md
Name: tag_mac_backoff

Overview:
Parametrised random-access MAC controller for the OFDM backscatter tag.
- Sits between the excitation trigger / MAC-enable inputs and the switching-circuit data path.
- Generalises the fixed trigger-gated modulator with:
  - binary-exponential random backoff,
  - configurable burst length and symbol duration,
  - random channel selection,
  - ack/collision-driven retry.
- Emits payload words to the switching circuit only inside its granted transmit slot.

Parameters:
DATA_WIDTH, 20, payload/output word width
NUM_CH, 4, subcarrier channels; power of two, >=2
SLOT_CYCLES, 64, clock cycles per backoff slot (>=2)
SYMBOL_CYCLES, 16, cycles each output word is held (>=1)
BURST_LEN, 8, words per transmission (>=1)
CW_MIN_LOG2, 2, initial contention window exponent (>=1)
CW_MAX_LOG2, 6, maximum contention window exponent (<=15)
MAX_RETRY, 3, failed attempts before giving up (>=1)
ACK_TIMEOUT, 256, cycles to wait for ack/collision after burst
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 1

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high
trigger_signal  input  1  excitation detect; rising edge requests access
mac_control_signal  input  1  MAC enable, level
ack  input  1  single-cycle pulse: reader acknowledged
collision  input  1  single-cycle pulse: reader reported collision
tx_data  input  DATA_WIDTH  payload word from data source
data_req  output  1  single-cycle pulse: tx_data sampled this cycle
output_signal  output  DATA_WIDTH  word to switching circuit
tx_active  output  1  high while output_signal carries payload
tx_channel  output  clog2(NUM_CH)  channel for current burst
retry_exhausted  output  1  single-cycle pulse on give-up
mac_state  output  3  encoded FSM state, for debug

Behaviour:
- One clock domain (clock). reset is synchronous and active-high.
- Reset values:
  - output_signal=0, tx_active=0, data_req=0, tx_channel=0, retry_exhausted=0, mac_state=IDLE.
  - Retry count=0, cw_log2=CW_MIN_LOG2, LFSR=seed, trig_d=1.
  - trig_d=1 ensures a trigger already high at reset release is not an edge.
  - Reset asserted mid-operation aborts everything and applies these values at that edge.
- Edge detect: edge = trigger_signal & ~trig_d; trig_d registers trigger_signal every cycle.
- LFSR:
  - 16-bit Galois, right shift, tap mask 16'hB400.
  - Advances every cycle, including while idle.
  - draw = lfsr & ((1<<cw_log2)-1).
- IDLE:
  - edge & mac_control_signal -> BACKOFF.
  - Latch slots=draw and slot_timer=SLOT_CYCLES-1.
- BACKOFF:
  - slot_timer decrements each cycle.
  - At slot_timer==0: if slots==0 -> TX; else slots-1 and reload the timer.
  - Total BACKOFF duration is exactly (draw+1)*SLOT_CYCLES cycles.
  - mac_control_signal low -> IDLE next cycle; cw_log2 and retry count preserved.
  - Further trigger edges are ignored.
- TX entry: tx_channel <= lfsr[clog2(NUM_CH)-1:0]; word and symbol counters cleared.
- TX:
  - data_req pulses in the first cycle of each symbol.
  - output_signal <= tx_data on the next cycle and is held SYMBOL_CYCLES cycles.
  - tx_active is high exactly while a payload word is on output_signal: BURST_LEN*SYMBOL_CYCLES cycles, starting one cycle after the first data_req.
  - The burst is not abortable by mac_control_signal.
  - After the last symbol: output_signal=0, tx_active=0 -> WAIT_ACK.
- WAIT_ACK:
  - Timeout counter starts at 0.
  - ack -> IDLE; cw_log2=CW_MIN_LOG2; retry=0.
  - collision, or counter reaching ACK_TIMEOUT-1 -> failure:
    - retry+1.
    - If new retry==MAX_RETRY: pulse retry_exhausted, go to IDLE, reset cw_log2 and retry.
    - Otherwise: cw_log2=min(cw_log2+1, CW_MAX_LOG2), go to BACKOFF with a fresh draw.
  - ack and collision in the same cycle: ack wins.
  - ack/collision outside WAIT_ACK are ignored.
- mac_state encoding: IDLE=0, BACKOFF=1, TX=2, WAIT_ACK=3.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package tag_mac_pkg:
  - mac_state_t enum (above encoding),
  - LFSR_TAPS=16'hB400,
  - clog2 function.
- Sub-module tag_lfsr16: seed parameter; enable, reset, 16-bit state out.
- FSM, counters and output register live in tag_mac_backoff.

Test Plan:
1. Reset then trigger rising with mac_control=1 -> BACKOFF length in {64,128,192,256} cycles matching the LFSR model. Then 8 data_req pulses 16 cycles apart; tx_active high 128 cycles; output_signal equals each tx_data word one cycle after its data_req.
2. Trigger held high through reset release -> no access. Later 0->1 edge with mac_control=0 -> stays IDLE; output_signal stays 0.
3. ack pulse 10 cycles into WAIT_ACK -> IDLE. A subsequent access draws from cw_log2=2 (backoff <=256 cycles).
4. Collision on each of 3 attempts:
   - cw_log2 goes 2->3->4 between attempts; backoffs are bounded by 512 and 1024 cycles.
   - After the third failure, retry_exhausted pulses once and the FSM enters IDLE.
5. No ack/collision -> failure exactly 256 cycles after WAIT_ACK entry. ack and collision in the same cycle -> treated as ack.
6. mac_control dropped mid-BACKOFF -> IDLE next cycle, no data_req. Reset asserted mid-TX -> all outputs 0 at the next edge.
